icache_fetch: RTL and testbench

Parametrised instruction-fetch unit with an integrated direct-mapped instruction cache. It generalises the fixed 16×16-word fetch stage: geometry is configurable, the PC advances sequentially, rollback redirects the PC, downstream back-pressure is honoured, and a cache-invalidate command is supported. It sits between the memory controller (line refill) and decode/dispatch (one instruction per cycle).

---
 rtl/icache_fetch.sv | 144 ++++++++++++++
 tb/tb_icache_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Instruction-fetch unit with a direct-mapped instruction cache and line refill port.
// Issues one instruction per cycle on a hit, refills one line at a time on a miss.
module icache_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          LINE_NUM   = 16,
  parameter int          LINE_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [31:0]             rollback_pc,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    mem_en,
  output logic [31:0]             mem_addr,
  input  logic                    mem_done,
  input  logic [32*LINE_WORDS-1:0] mem_data,
  output logic                    inst_done,
  output logic [31:0]             inst,
  output logic [31:0]             inst_pc
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic {S_IDLE, S_FETCH} status_t;

  status_t                    r_status, w_status_next;
  logic                       r_stale, w_stale_next;
  logic                       r_mem_en, w_mem_en_next;
  logic [31:0]                r_mem_addr, w_mem_addr_next;
  logic                       w_fill;
  logic [31:0]                r_pc;
  logic                       r_inst_done;
  logic [31:0]                r_inst;
  logic [31:0]                r_inst_pc;

  logic [LINE_NUM-1:0]         r_valid;
  logic [TAG_W-1:0]            r_tag  [LINE_NUM];
  logic [32*LINE_WORDS-1:0]    r_data [LINE_NUM];

  logic [IDX_W-1:0]            w_pc_idx;
  logic [OFF_W-1:0]            w_pc_off;
  logic [TAG_W-1:0]            w_pc_tag;
  logic [IDX_W-1:0]            w_fill_idx;
  logic [TAG_W-1:0]            w_fill_tag;
  logic [32*LINE_WORDS-1:0]    w_line;
  logic [31:0]                 w_words [LINE_WORDS];
  logic                        w_hit;

  assign w_pc_idx   = r_pc[OFF_W+2 +: IDX_W];
  assign w_pc_off   = r_pc[2 +: OFF_W];
  assign w_pc_tag   = r_pc[31 -: TAG_W];
  assign w_fill_idx = r_mem_addr[OFF_W+2 +: IDX_W];
  assign w_fill_tag = r_mem_addr[31 -: TAG_W];
  assign w_line     = r_data[w_pc_idx];
  assign w_hit      = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);

  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign w_words[gi] = w_line[32*gi +: 32];
    end
  endgenerate

  // Refill FSM; a flush racing an outstanding refill marks the returning line stale.
  always_comb begin
    w_status_next   = r_status;
    w_stale_next    = r_stale;
    w_mem_en_next   = r_mem_en;
    w_mem_addr_next = r_mem_addr;
    w_fill          = 1'b0;
    if (r_status == S_IDLE) begin
      if (!w_hit) begin
        w_status_next   = S_FETCH;
        w_mem_en_next   = 1'b1;
        w_mem_addr_next = {r_pc[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        w_stale_next    = flush;
      end
    end else begin
      if (mem_done) begin
        w_fill        = 1'b1;
        w_status_next = S_IDLE;
        w_mem_en_next = 1'b0;
        w_stale_next  = 1'b0;
      end else if (flush) begin
        w_stale_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status    <= S_IDLE;
      r_stale     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_valid     <= '0;
      r_pc        <= RESET_PC;
      r_inst_done <= 1'b0;
      r_inst      <= 32'h0;
      r_inst_pc   <= 32'h0;
    end else if (rdy) begin
      r_status   <= w_status_next;
      r_stale    <= w_stale_next;
      r_mem_en   <= w_mem_en_next;
      r_mem_addr <= w_mem_addr_next;

      if (rollback) begin
        r_pc        <= rollback_pc;
        r_inst_done <= 1'b0;
      end else if (w_hit && !stall) begin
        r_inst_done <= 1'b1;
        r_inst      <= w_words[w_pc_off];
        r_inst_pc   <= r_pc;
        r_pc        <= r_pc + 32'd4;
      end else begin
        r_inst_done <= 1'b0;
      end

      // Flush wins over the valid set of a coincident fill.
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_fill_idx] <= !r_stale;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_data[w_fill_idx] <= mem_data;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign inst_done = r_inst_done;
  assign inst      = r_inst;
  assign inst_pc   = r_inst_pc;

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: expected {pc, inst} pushed when the fetch path is
// steered, popped and compared on every inst_done pulse.
module tb_icache_fetch;

  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              rst, rdy, rollback, stall, flush, mem_done;
  logic [31:0]       rollback_pc;
  logic [32*LW-1:0]  mem_data;
  logic              mem_en, inst_done;
  logic [31:0]       mem_addr, inst, inst_pc;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  icache_fetch #(.RESET_PC(32'h0), .LINE_NUM(16), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .stall(stall), .flush(flush), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data), .inst_done(inst_done),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  function automatic logic [32*LW-1:0] line_at(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int k = 0; k < LW; k++) l[32*k +: 32] = word_at(base + 32'(4*k));
    return l;
  endfunction

  task automatic push_range(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      a = start + 32'(4*k);
      exp_q.push_back({a, word_at(a)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_mem_en(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (!mem_en && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, "_en"}, 32'(mem_en), 32'd1);
    check_eq({tag, "_addr"}, mem_addr, addr);
  endtask

  task automatic serve(input string tag, input logic [31:0] base, input int lat);
    wait_mem_en(tag, base);
    repeat (lat) tick();
    mem_data = line_at(base);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    $display("refill addr=0x%08h", base);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: a pulse counts only on an edge where rdy was high.
  initial begin
    logic s_rdy, s_rst;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      s_rdy = rdy;
      s_rst = rst;
      #1;
      if (!s_rst && s_rdy && inst_done) begin
        $display("inst pc=0x%08h inst=0x%08h", inst_pc, inst);
        if (exp_q.size() == 0) begin
          check_eq("spurious_pulse", 32'(inst_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("inst_pc", inst_pc, e[63:32]);
          check_eq("inst", inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0;
    stall = 1'b0; flush = 1'b0; mem_done = 1'b0; mem_data = '0;
    repeat (3) tick();
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_inst_done", 32'(inst_done), 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    rst = 1'b0;

    // Cold start with a 3-cycle stall after the fourth pulse.
    push_range(32'h0, 16);
    serve("cold", 32'h0, 3);
    check_eq("cold_fill_clr", 32'(mem_en), 32'd0);
    tick();
    check_eq("first_pulse", 32'(inst_done), 32'd1);
    repeat (3) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_quiet", 32'(inst_done), 32'd0);
    end
    stall = 1'b0;
    tick();
    check_eq("stall_resume", 32'(inst_done), 32'd1);
    drain(40);

    // Rollback while line 0x40 is being refilled; the refill must still land.
    wait_mem_en("next_line", 32'h40);
    push_range(32'h8, 30);
    rollback = 1'b1; rollback_pc = 32'h8;
    tick();
    rollback = 1'b0;
    check_eq("rb_gap", 32'(inst_done), 32'd0);
    tick();
    check_eq("rb_first", 32'(inst_done), 32'd1);
    serve("rb_fill", 32'h40, 2);
    check_eq("rb_fill_clr", 32'(mem_en), 32'd0);
    drain(60);
    wait_mem_en("after_rb", 32'h80);

    // Flush during refill: the returning line is stale and is requested again.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    serve("stale_fill", 32'h80, 2);
    check_eq("stale_clr", 32'(mem_en), 32'd0);
    push_range(32'h80, 16);
    serve("refetch", 32'h80, 1);
    drain(40);
    wait_mem_en("after_flush", 32'hC0);

    // Aliasing: 0x0 and 0x400 share an index.
    stall = 1'b1;
    rollback = 1'b1; rollback_pc = 32'h0;
    tick();
    rollback = 1'b0;
    serve("c0_fill", 32'hC0, 1);
    serve("flushed_0", 32'h0, 1);
    push_range(32'h0, 1);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    rollback = 1'b1; rollback_pc = 32'h400;
    tick();
    rollback = 1'b0;
    drain(3);
    serve("alias_fill", 32'h400, 1);
    push_range(32'h400, 1);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    rollback = 1'b1; rollback_pc = 32'h0;
    tick();
    rollback = 1'b0;
    drain(3);
    wait_mem_en("alias_miss", 32'h0);

    // rdy low with mem_done held: nothing moves until rdy returns.
    mem_data = line_at(32'h0);
    mem_done = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rdy_hold_en", 32'(mem_en), 32'd1);
      check_eq("rdy_hold_addr", mem_addr, 32'h0);
    end
    rdy = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq("rdy_fill", 32'(mem_en), 32'd0);
    push_range(32'h0, 16);
    stall = 1'b0;
    drain(40);
    wait_mem_en("final", 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
